// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator that turns execute-stage commands into word-aligned memory requests.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two requests; otherwise they complete with rsp_err.
module lsu_mem_master #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [1:0]    cmd_size,
  input  logic          cmd_unsigned,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ0  = 3'd1;
  localparam logic [2:0] WAIT0 = 3'd2;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic [2:0] REQ1  = 3'd3;
  localparam logic [2:0] WAIT1 = 3'd4;
  localparam int LANES = 8;
`else
  localparam int LANES = 4;
`endif
  localparam logic [2:0] RESP  = 3'd5;

  typedef logic [LANES*8-1:0] lane_t;

  logic [2:0]       state;
  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             err_q;
  logic             got_q;
  logic [AW-1:0]    addr_q;
  logic [LANES-1:0] be_q;
  lane_t            wd_q;
  logic [DW-1:0]    rd0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [DW-1:0]    rd1_q;
  logic             split;
  assign split = |be_q[7:4];
`endif

  // Byte enables over two words: the high nibble marks lanes spilling into the next word.
  logic [7:0] cmd_be8;
  always_comb begin
    case (cmd_size)
      2'b00:   cmd_be8 = 8'b0000_0001 << cmd_addr[1:0];
      2'b01:   cmd_be8 = 8'b0000_0011 << cmd_addr[1:0];
      2'b10:   cmd_be8 = 8'b0000_1111 << cmd_addr[1:0];
      default: cmd_be8 = 8'h00;
    endcase
  end

  lane_t cmd_wd_sh;
  assign cmd_wd_sh = lane_t'(cmd_wdata) << {cmd_addr[1:0], 3'b000};

  // Read data is registered first and the state advances the cycle after rvalid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      size_q <= 2'b00;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      got_q  <= 1'b0;
      addr_q <= '0;
      be_q   <= '0;
      wd_q   <= '0;
      rd0_q  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      rd1_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          we_q   <= cmd_we;
          size_q <= cmd_size;
          uns_q  <= cmd_unsigned;
          addr_q <= cmd_addr;
          be_q   <= cmd_be8[LANES-1:0];
          wd_q   <= cmd_wd_sh;
          got_q  <= 1'b0;
          rd0_q  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          rd1_q  <= '0;
`endif
          if (cmd_size == 2'b11) begin
            err_q <= 1'b1;
            state <= RESP;
          end
`ifndef LSU_MISALIGN_SPLIT_EN
          else if (|cmd_be8[7:4]) begin
            err_q <= 1'b1;
            state <= RESP;
          end
`endif
          else begin
            err_q <= 1'b0;
            state <= REQ0;
          end
        end
        REQ0: if (mem_gnt) begin
          if (!we_q)      state <= WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
          else if (split) state <= REQ1;
`endif
          else            state <= RESP;
        end
        WAIT0: if (got_q) begin
          got_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
          state <= split ? REQ1 : RESP;
`else
          state <= RESP;
`endif
        end else if (mem_rvalid) begin
          rd0_q <= mem_rdata;
          got_q <= 1'b1;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        REQ1: if (mem_gnt) state <= we_q ? RESP : WAIT1;
        WAIT1: if (got_q) begin
          got_q <= 1'b0;
          state <= RESP;
        end else if (mem_rvalid) begin
          rd1_q <= mem_rdata;
          got_q <= 1'b1;
        end
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [AW-1:0] word_addr;
  assign word_addr = {addr_q[AW-1:2], 2'b00};

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state)
      REQ0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_addr;
        mem_wdata = wd_q[DW-1:0];
        mem_be    = be_q[3:0];
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      REQ1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_addr + AW'(4);
        mem_wdata = wd_q[2*DW-1:DW];
        mem_be    = be_q[7:4];
      end
`endif
      default: ;
    endcase
  end

  logic [DW-1:0] rd_sh;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [2*DW-1:0] rd_all;
  assign rd_all = {rd1_q, rd0_q};
  assign rd_sh  = rd_all[{addr_q[1:0], 3'b000} +: DW];
`else
  assign rd_sh  = rd0_q >> {addr_q[1:0], 3'b000};
`endif

  logic [DW-1:0] rd_ext;
  always_comb begin
    rd_ext = rd_sh;
    case (size_q)
      2'b00:   rd_ext = {{(DW-8){~uns_q & rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   rd_ext = {{(DW-16){~uns_q & rd_sh[15]}}, rd_sh[15:0]};
      default: ;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? rd_ext : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed vector table plus hand-written reset/stall sequences for lsu_mem_master.
// Expectations follow the build: LSU_MISALIGN_SPLIT_EN selects the split or error outcome for misaligned vectors.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_unsigned;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_mem_master #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_size(cmd_size),
    .cmd_unsigned(cmd_unsigned), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          n_acc;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input int gnt_dly,
                              input logic [31:0] rd0, input logic [31:0] rd1, input int n_acc,
                              input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                              input logic err, input logic [31:0] rdata, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.gnt_dly = gnt_dly;
    v.rd0 = rd0; v.rd1 = rd1; v.n_acc = n_acc;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    v.err = err; v.rdata = rdata; v.lat = lat;
    return v;
  endfunction

  // Drives one command, acts as the memory, and checks requests and the response.
  task automatic run_vec(input int id, input vec_t v);
    int n, rv_due, stall, lat;
    bit done, stable;
    logic [31:0] acc_addr[2], acc_wd[2];
    logic [3:0]  acc_be[2];
    logic        acc_we[2];
    logic [31:0] s_addr, s_wd, r_data;
    logic [3:0]  s_be;
    logic        s_we, r_err;
    string tag;
    tag = $sformatf("v%0d", id);
    @(negedge clk);
    check({tag, " ready"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_size = v.size; cmd_unsigned = v.uns;
    cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~v.we; cmd_size = ~v.size; cmd_unsigned = ~v.uns;
    cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
    n = 0; rv_due = -1; stall = 0; lat = 0; done = 1'b0; stable = 1'b1;
    r_data = '0; r_err = 1'b0;
    s_addr = '0; s_wd = '0; s_be = '0; s_we = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      if (rsp_valid) begin
        done = 1'b1; lat = cyc; r_data = rsp_rdata; r_err = rsp_err;
      end else begin
        if (cyc == rv_due) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (n == 1) ? v.rd0 : v.rd1;
        end
        if (mem_req) begin
          if (stall == 0) begin
            s_addr = mem_addr; s_wd = mem_wdata; s_be = mem_be; s_we = mem_we;
          end else if (mem_addr !== s_addr || mem_wdata !== s_wd || mem_be !== s_be || mem_we !== s_we) begin
            stable = 1'b0;
          end
          if (stall < v.gnt_dly) begin
            stall++;
            mem_rvalid = 1'b1;
          end else begin
            mem_gnt = 1'b1;
            if (n < 2) begin
              acc_addr[n] = mem_addr; acc_wd[n] = mem_wdata; acc_be[n] = mem_be; acc_we[n] = mem_we;
            end
            n++;
            stall = 0;
            if (!v.we) rv_due = cyc + 1;
          end
        end
        @(negedge clk);
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!done) begin
      check({tag, " rsp timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " err"}, {31'b0, r_err}, {31'b0, v.err});
      check({tag, " rdata"}, r_data, v.rdata);
      check({tag, " n_acc"}, 32'(n), 32'(v.n_acc));
      for (int k = 0; k < 2; k++) begin
        if (k < v.n_acc && k < n) begin
          check($sformatf("%s addr%0d", tag, k), acc_addr[k], (k == 0) ? v.a0 : v.a1);
          check($sformatf("%s be%0d", tag, k), {28'b0, acc_be[k]}, {28'b0, (k == 0) ? v.be0 : v.be1});
          check($sformatf("%s we%0d", tag, k), {31'b0, acc_we[k]}, {31'b0, v.we});
          if (v.we) check($sformatf("%s wdata%0d", tag, k), acc_wd[k], (k == 0) ? v.wd0 : v.wd1);
        end
      end
      if (v.lat != 0) check({tag, " latency"}, 32'(lat), 32'(v.lat));
      if (v.gnt_dly != 0) check({tag, " stall stable"}, {31'b0, stable}, 32'd1);
      @(negedge clk);
      check({tag, " rsp pulse"}, {31'b0, rsp_valid}, 32'd0);
      check({tag, " ready after"}, {31'b0, cmd_ready}, 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit quiet;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_size = 2'b00; cmd_unsigned = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    //            we    sz     u     addr          wdata         dly rd0           rd1           n  a0            be0      wd0           a1            be1      wd1           err   rdata         lat
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,        32'h0,        1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        2));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        0, 32'h80AA_BBCC, 32'h0,        1, 32'h0000_0010, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'hFFFF_FF80, 4));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        0, 32'h80AA_BBCC, 32'h0,        1, 32'h0000_0010, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h0000_0080, 4));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,        3, 32'h8001_1234, 32'h0,        1, 32'h0000_0020, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'hFFFF_8001, 0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,        0, 32'hF00D_0000, 32'h0,        1, 32'h0000_0000, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h0000_F00D, 4));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,        0, 32'h0000_7F00, 32'h0,        1, 32'h0000_0000, 4'b0010, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h0000_007F, 4));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_56A5, 0, 32'h0,        32'h0,        1, 32'h0000_0004, 4'b0010, 32'h3456_A500, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        2));
    vecs.push_back(mk(1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0,        0, 32'h89AB_CDEF, 32'h0,        1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h89AB_CDEF, 4));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0,        0));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_000D, 32'h0,        0, 32'h4433_2211, 32'h8877_6655, 2, 32'h0000_000C, 4'b1110, 32'h0,        32'h0000_0010, 4'b0001, 32'h0,        1'b0, 32'h5544_3322, 0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD, 0, 32'h0,        32'h0,        2, 32'hFFFF_FFFC, 4'b1000, 32'hCD00_0000, 32'h0000_0000, 4'b0001, 32'h0000_00AB, 1'b0, 32'h0,        0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h1122_3344, 1, 32'h0,        32'h0,        2, 32'h0000_0004, 4'b1100, 32'h3344_0000, 32'h0000_0008, 4'b0011, 32'h0000_1122, 1'b0, 32'h0,        0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,        1, 32'hC011_2233, 32'h4455_66FE, 2, 32'h0000_0000, 4'b1000, 32'h0,        32'h0000_0004, 4'b0001, 32'h0,        1'b0, 32'hFFFF_FEC0, 0));
`else
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_000D, 32'h0,        0, 32'h4433_2211, 32'h8877_6655, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0,        0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD, 0, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0,        0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h1122_3344, 0, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0,        0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0,        0));
`endif

    // Reset values while rst is held.
    @(posedge clk);
    @(negedge clk);
    check("rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'd0);
    check("rst rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst mem_req", {31'b0, mem_req}, 32'd0);
    check("rst mem_we", {31'b0, mem_we}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst mem_be", {28'b0, mem_be}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset during WAIT0 aborts the load; a late rvalid must not revive it.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_size = 2'b10; cmd_unsigned = 1'b0; cmd_addr = 32'h0000_0200;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort req", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("abort in wait ready", {31'b0, cmd_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort mem_req", {31'b0, mem_req}, 32'd0);
    check("abort cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rsp_valid || mem_req || !cmd_ready) quiet = 1'b0;
    end
    check("abort late rvalid ignored", {31'b0, quiet}, 32'd1);

    run_vec(100, vecs[2]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator for the word-organised data memory.
- Accepts one load or store command at a time from the execute stage.
- Converts each command to word-aligned memory accesses carrying byte enables and lane-shifted write data.
- Returns load data sign- or zero-extended.
- Misaligned accesses are split into two word accesses (see Optional Feature).

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; fixed at 32, 4 byte lanes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_we  in  1  1 = store, 0 = load.
- cmd_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- cmd_unsigned  in  1  zero-extend load result (LBU/LHU).
- cmd_addr  in  AW  byte address.
- cmd_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: illegal size or misaligned access (no-split build).
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_addr  out  AW  word address; bits [1:0] always 0.
- mem_wdata  out  32  lane-shifted write data.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; arrives 1 or more cycles after gnt.
- mem_rdata  in  32  read word.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. FSM goes to IDLE.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: handshake when cmd_valid && cmd_ready; all cmd_* fields are registered. Go to REQ0, or to RESP with err=1 if size is 11.
- REQ0 / REQ1: mem_req is held with stable outputs until mem_gnt.
  - On gnt for a load: go to WAIT0 / WAIT1.
  - On gnt for a store: go to REQ1 if split and in REQ0, else RESP.
- WAIT0 / WAIT1: capture mem_rdata on mem_rvalid into rd0 / rd1. Then go to REQ1 (if split) or RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- mem_rvalid outside WAIT states is ignored.
- Offset: off = addr[1:0].
- Byte enables: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111<<off, computed over 8 bits.
  - Low nibble drives access 0.
  - High nibble drives access 1, which is needed iff the high nibble is non-zero.
- Write data: 64-bit {32'b0, wdata}<<(8*off). Low word goes to access 0, high word to access 1.
- Access addresses: access 0 at {addr[31:2],2'b00}; access 1 at that address + 4. 0xFFFFFFFC wraps to 0x00000000.
- Load data: ({rd1,rd0}>>(8*off)), truncated to the access size, then sign-extended unless cmd_unsigned.
  - rd1 is 0 when there is no split.
  - cmd_unsigned is ignored for word loads.
- Latency: aligned load with gnt in the first REQ0 cycle and rvalid on the next cycle gives rsp_valid 4 cycles after the handshake cycle. Aligned store gives rsp_valid 2 cycles after the handshake.
- Reset mid-operation: on the cycle after rst is sampled high, mem_req=0 and the FSM is in IDLE. No rsp_valid is produced for the aborted command. In-flight rvalid is ignored.
- cmd_* inputs may change freely while not in IDLE; they have no effect.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split into two memory accesses as described above.
- Undefined: any access whose byte enables cross a word boundary goes directly to RESP with rsp_err=1 and rsp_rdata=0, and no memory request is issued. REQ1 and WAIT1 are removed.

Test Plan:
- Aligned SW: addr 0x10, wdata 0xDEADBEEF, gnt immediate -> one request with mem_addr 0x10, be 1111, mem_wdata 0xDEADBEEF; rsp_valid 2 cycles after handshake, rsp_err 0.
- LB signed: addr 0x13, mem_rdata 0x80AABBCC -> be 1000, rsp_rdata 0xFFFFFF80. Same with LBU -> 0x00000080.
- LH at 0x22 with gnt held low 3 cycles -> mem_req and all mem_* outputs stable across the stall. mem_rdata 0x8001xxxx gives rsp_rdata 0xFFFF8001.
- Misaligned LW at 0x0000000D, split build, rd0 0x44332211, rd1 0x88776655 -> accesses to 0x0C (be 1110) then 0x10 (be 0001); rsp_rdata 0x55443322. Same command in no-split build -> no mem_req, rsp_err 1.
- Misaligned SH at 0xFFFFFFFF, wdata 0x0000ABCD, split build -> access at 0xFFFFFFFC with be 1000, wdata 0xCD000000; then access at 0x00000000 with be 0001, wdata 0x000000AB.
- Illegal size 11 -> rsp_err 1 with no mem_req. Separately, rst asserted during WAIT0 -> mem_req 0 and cmd_ready 1 the next cycle, no rsp_valid, and a later rvalid is ignored.
